serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//  Transmit side of the serial bit-stream link that the moore sequence detector receives.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first,
//  one bit per clk, on serial_out.
//  Enforces a GAP-cycle idle interval between frames and counts completed frames.
//  Drives the detector's serial input in loopback benches and at system level.
// PARAMETERS
//  WIDTH     4   bits per frame (>=2)
//  GAP       2   idle cycles inserted after each frame (0 allowed)
//  IDLE_VAL  0   level driven on serial_out when not shifting
//  CNT_W     8   width of frame_count
// PORTS
//  clk          in   1        system clock, rising-edge
//  rst          in   1        asynchronous reset, active-high
//  data_in      in   WIDTH    frame to send; bit WIDTH-1 is sent first
//  data_valid   in   1        data_in holds a frame to send
//  data_ready   out  1        block can accept a frame this cycle
//  serial_out   out  1        serial bit stream (registered)
//  serial_en    out  1        1 while serial_out carries a frame bit (registered)
//  frame_done   out  1        1-cycle pulse after the last bit of a frame
//  frame_count  out  CNT_W    completed frames, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, serial_out=IDLE_VAL, serial_en=0, frame_done=0,
//   frame_count=0. Shift register and bit counter are cleared.
//   data_ready=1 once rst deasserts.
//  States:
//   - IDLE: data_ready=1. On an edge with data_valid=1, load data_in into the shift register,
//     clear bit_cnt, go to SHIFT. data_valid=0 keeps the block in IDLE.
//   - SHIFT: data_ready=0, serial_en=1, serial_out=shift_reg[WIDTH-1].
//     Each edge shifts left by 1 and increments bit_cnt.
//     After WIDTH cycles go to GAP (GAP>0) or IDLE (GAP=0).
//   - GAP: data_ready=0, serial_en=0, serial_out=IDLE_VAL. Hold for exactly GAP cycles, then IDLE.
//  Handshake: transfer only on an edge with data_valid && data_ready.
//   data_valid during SHIFT/GAP is ignored, with no queueing.
//   data_in changes after acceptance do not affect the frame in flight.
//  Latency: accept at edge k. Frame bit j appears on serial_out for the cycle after edge k+j,
//   for j=0..WIDTH-1.
//  frame_done is high for the one cycle after edge k+WIDTH.
//   frame_count increments on that same edge, wrapping from all-ones to 0.
//  Back-to-back with data_valid held high: serial_en is low for exactly GAP+1 cycles between
//   frames (GAP cycles plus one IDLE accept cycle).
//  Bit counter width is clog2(WIDTH). No reachable state lets serial_en stay high longer than
//   WIDTH consecutive cycles.
//  Reset mid-frame aborts immediately. The partial frame is not counted and no frame_done is
//   issued. The next frame starts from IDLE.
//  Illegal or unreachable state encodings recover to IDLE on the next edge.
// TESTING
//  1 Reset: rst=1 for 2 cycles mid-clock -> serial_out=0, serial_en=0, frame_done=0,
//    frame_count=0, data_ready=1 after release.
//  2 Single frame: data_in=4'b1101, valid 1 cycle -> serial_out 1,1,0,1 on 4 consecutive cycles
//    with serial_en=1, then frame_done pulse, frame_count=1.
//  3 Back-to-back: data_in 4'b1101 then 4'b0110, valid held, GAP=2 -> streams 1101, 3 idle
//    cycles at 0, then 0110; frame_count=2; data_ready low throughout each SHIFT+GAP.
//  4 Busy ignore: pulse data_valid with 4'b0000 during SHIFT of 4'b1011 -> output remains
//    1011, no extra frame; frame_count=1.
//  5 Loopback: serial_out feeds the moore 1101 detector input. Send 4'b1101 -> detector o=1
//    after the 4th bit. Send 4'b0110 after reset -> detector o stays 0.
//  6 Abort/wrap: rst asserted after 2 bits of 4'b1101 -> outputs reset, no frame_done.
//    With CNT_W=2, send 4 frames -> frame_count 1,2,3,0.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: accepts a WIDTH-bit word over valid/ready and shifts it
// out MSB-first, then holds the line idle for GAP cycles before accepting the next word.
module serial_pattern_tx #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned GAP      = 2,
  parameter logic        IDLE_VAL = 1'b0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_en,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_serial_out;
  logic               r_serial_en;
  logic               r_frame_done;
  logic [CNT_W-1:0]   r_frame_count;
  logic               r_data_ready;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic               w_serial_out_nxt;
  logic               w_serial_en_nxt;
  logic               w_frame_done_nxt;
  logic [CNT_W-1:0]   w_frame_count_nxt;

  // State and registered outputs; the shift register holds only the bits not yet sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_serial_out  <= IDLE_VAL;
      r_serial_en   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_data_ready  <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_serial_out  <= w_serial_out_nxt;
      r_serial_en   <= w_serial_en_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_data_ready  <= (w_state_nxt == ST_IDLE);
    end
  end

  // Next-state and next-output logic; the first frame bit is registered on the accept edge.
  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_serial_out_nxt  = IDLE_VAL;
    w_serial_en_nxt   = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_frame_count_nxt = r_frame_count;

    case (r_state)
      ST_IDLE: begin
        if (data_valid && r_data_ready) begin
          w_shift_nxt      = {data_in[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt    = '0;
          w_serial_out_nxt = data_in[WIDTH-1];
          w_serial_en_nxt  = 1'b1;
          w_state_nxt      = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_frame_done_nxt  = 1'b1;
          w_frame_count_nxt = r_frame_count + CNT_W'(1);
          w_gap_cnt_nxt     = '0;
          w_shift_nxt       = '0;
          w_state_nxt       = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          w_serial_out_nxt = r_shift[WIDTH-1];
          w_serial_en_nxt  = 1'b1;
          w_shift_nxt      = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt    = r_bit_cnt + BIT_W'(1);
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == LAST_GAP) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign data_ready  = r_data_ready;
  assign serial_out  = r_serial_out;
  assign serial_en   = r_serial_en;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: reset, single frame, back-to-back, busy ignore,
// loopback into a 1101 Moore detector, mid-frame abort and frame counter wrap.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       serial_out;
  logic       serial_en;
  logic       frame_done;
  logic [7:0] frame_count;

  logic       rst2 = 1'b1;
  logic [3:0] data_in2 = '0;
  logic       data_valid2 = 1'b0;
  logic       data_ready2;
  logic       serial_out2;
  logic       serial_en2;
  logic       frame_done2;
  logic [1:0] frame_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(4), .GAP(2), .IDLE_VAL(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .serial_out(serial_out), .serial_en(serial_en),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  serial_pattern_tx #(.WIDTH(4), .GAP(2), .IDLE_VAL(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .data_in(data_in2), .data_valid(data_valid2),
    .data_ready(data_ready2), .serial_out(serial_out2), .serial_en(serial_en2),
    .frame_done(frame_done2), .frame_count(frame_count2)
  );

  // Moore 1101 detector (overlapping) fed from serial_out
  typedef enum logic [2:0] {D0, D1, D11, D110, D1101} det_t;
  det_t det_st;
  logic det_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_st <= D0;
    else begin
      case (det_st)
        D0:      det_st <= serial_out ? D1    : D0;
        D1:      det_st <= serial_out ? D11   : D0;
        D11:     det_st <= serial_out ? D11   : D110;
        D110:    det_st <= serial_out ? D1101 : D0;
        D1101:   det_st <= serial_out ? D11   : D0;
        default: det_st <= D0;
      endcase
    end
  end
  assign det_o = (det_st == D1101);

  task automatic do_reset;
    rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #2 rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (serial_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", serial_en); end
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", serial_out); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", data_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", frame_count); end
    checks++; if (serial_en !== 1'b0) begin errors++; $display("FAIL reset_en_rel got %b want 0", serial_en); end
  endtask

  task automatic test_single;
    logic [6:0] e_en, e_out, e_done, e_rdy;
    e_en = 7'b1111000; e_out = 7'b1101000; e_done = 7'b0000100; e_rdy = 7'b0000001;
    do_reset();
    data_in = 4'b1101;
    data_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) data_valid = 1'b0;
      checks++; if (serial_en !== e_en[7-i]) begin errors++; $display("FAIL single_en n%0d got %b want %b", i, serial_en, e_en[7-i]); end
      checks++; if (serial_out !== e_out[7-i]) begin errors++; $display("FAIL single_out n%0d got %b want %b", i, serial_out, e_out[7-i]); end
      checks++; if (frame_done !== e_done[7-i]) begin errors++; $display("FAIL single_done n%0d got %b want %b", i, frame_done, e_done[7-i]); end
      checks++; if (data_ready !== e_rdy[7-i]) begin errors++; $display("FAIL single_rdy n%0d got %b want %b", i, data_ready, e_rdy[7-i]); end
    end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", frame_count); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] e_en, e_out, e_done, e_rdy;
    e_en   = 12'b111100011110;
    e_out  = 12'b110100001100;
    e_done = 12'b000010000001;
    e_rdy  = 12'b000000100000;
    do_reset();
    data_in = 4'b1101;
    data_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++; if (serial_en !== e_en[12-i]) begin errors++; $display("FAIL b2b_en n%0d got %b want %b", i, serial_en, e_en[12-i]); end
      checks++; if (serial_out !== e_out[12-i]) begin errors++; $display("FAIL b2b_out n%0d got %b want %b", i, serial_out, e_out[12-i]); end
      checks++; if (frame_done !== e_done[12-i]) begin errors++; $display("FAIL b2b_done n%0d got %b want %b", i, frame_done, e_done[12-i]); end
      checks++; if (data_ready !== e_rdy[12-i]) begin errors++; $display("FAIL b2b_rdy n%0d got %b want %b", i, data_ready, e_rdy[12-i]); end
      if (i == 1) data_in = 4'b0110;
      if (i == 8) data_valid = 1'b0;
    end
    checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", frame_count); end
  endtask

  task automatic test_busy_ignore;
    logic [9:0] e_en, e_out, e_done;
    e_en = 10'b1111000000; e_out = 10'b1011000000; e_done = 10'b0000100000;
    do_reset();
    data_in = 4'b1011;
    data_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (serial_en !== e_en[10-i]) begin errors++; $display("FAIL busy_en n%0d got %b want %b", i, serial_en, e_en[10-i]); end
      checks++; if (serial_out !== e_out[10-i]) begin errors++; $display("FAIL busy_out n%0d got %b want %b", i, serial_out, e_out[10-i]); end
      checks++; if (frame_done !== e_done[10-i]) begin errors++; $display("FAIL busy_done n%0d got %b want %b", i, frame_done, e_done[10-i]); end
      if (i == 1) data_valid = 1'b0;
      if (i == 2) begin data_in = 4'b0000; data_valid = 1'b1; end
      if (i == 3) data_valid = 1'b0;
    end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL busy_count got %0d want 1", frame_count); end
  endtask

  task automatic test_loopback;
    logic [5:0] e_det;
    e_det = 6'b000010;
    do_reset();
    data_in = 4'b1101;
    data_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) data_valid = 1'b0;
      checks++; if (det_o !== e_det[6-i]) begin errors++; $display("FAIL loop_1101 n%0d got %b want %b", i, det_o, e_det[6-i]); end
    end
    do_reset();
    data_in = 4'b0110;
    data_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) data_valid = 1'b0;
      checks++; if (det_o !== 1'b0) begin errors++; $display("FAIL loop_0110 n%0d got %b want 0", i, det_o); end
    end
  endtask

  task automatic test_abort;
    do_reset();
    data_in = 4'b1101;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL abort_bit0 got %b want 1", serial_out); end
    @(negedge clk);
    checks++; if (serial_en !== 1'b1) begin errors++; $display("FAIL abort_bit1_en got %b want 1", serial_en); end
    rst = 1'b1;
    #1;
    checks++; if (serial_en !== 1'b0) begin errors++; $display("FAIL abort_imm_en got %b want 0", serial_en); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 4; i <= 7; i++) begin
      @(negedge clk);
      checks++; if (serial_en !== 1'b0) begin errors++; $display("FAIL abort_en n%0d got %b want 0", i, serial_en); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_done n%0d got %b want 0", i, frame_done); end
      checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL abort_count n%0d got %0d want 0", i, frame_count); end
      checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL abort_rdy n%0d got %b want 1", i, data_ready); end
    end
    data_in = 4'b1001;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    checks++; if (serial_out !== 1'b1 || serial_en !== 1'b1) begin errors++; $display("FAIL abort_restart got out=%b en=%b want out=1 en=1", serial_out, serial_en); end
  endtask

  task automatic test_wrap;
    logic [1:0] e_cnt [4];
    e_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    checks++; if (frame_count2 !== 2'd0) begin errors++; $display("FAIL wrap_reset got %0d want 0", frame_count2); end
    for (int f = 0; f < 4; f++) begin
      data_in2 = 4'b1010;
      data_valid2 = 1'b1;
      for (int i = 1; i <= 7; i++) begin
        @(negedge clk);
        if (i == 1) data_valid2 = 1'b0;
        if (i == 5) begin
          checks++; if (frame_done2 !== 1'b1) begin errors++; $display("FAIL wrap_done f%0d got %b want 1", f, frame_done2); end
          checks++; if (frame_count2 !== e_cnt[f]) begin errors++; $display("FAIL wrap_count f%0d got %0d want %0d", f, frame_count2, e_cnt[f]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_loopback();
    test_abort();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
